fp_mult_seq: RTL and testbench
==============================

Name: fp_mult_seq

Overview:
- Parametrised, sequential IEEE-754-style floating-point multiplier with valid/ready handshake.
- Generalises the single-precision combinational multiplier in four ways:
  - configurable exponent and mantissa widths;
  - an iterative shift-add mantissa datapath, so no wide combinational multiplier is needed;
  - signed special results and 0*inf handling;
  - optional round-to-nearest-even.
- Sits between an operand producer and a result consumer in the lab datapath; same flag set: inf, nan, zero, overflow, underflow.

Parameters:
- EXP_W, 8: exponent field width. BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23: stored fraction width. Significand is MAN_W+1 bits with the hidden 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands X, Y are valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- X  in  1+EXP_W+MAN_W  operand {sign, exp, frac}.
- Y  in  1+EXP_W+MAN_W  operand.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  1+EXP_W+MAN_W  product.
- inf, nan, zero, overflow, underflow  out  1 each  status flags; exactly one set or none, valid with out_valid.

Behaviour:
- Clock/reset (already decided): one clock, clk; reset_n is synchronous, active-low.
- Reset: on any edge with reset_n=0:
  - state=IDLE; out_valid, result and all flags = 0; in_ready=1 afterwards.
  - Reset mid-operation abandons the operation; no partial output.
- FSM states: IDLE, MUL, NORM, DONE.
  - IDLE: in_ready=1. On in_valid, operands are registered and classified (see classification below).
    - Special case: result and flags are written, next state DONE, so out_valid is high 1 cycle after the accepting edge.
    - Otherwise: next state MUL; load acc=0, multiplicand=sigX, multiplier=sigY, cnt=0.
  - MUL: per cycle, if multiplier LSB=1 then acc += multiplicand<<cnt; multiplier >>= 1; cnt++. Exactly MAN_W+1 iterations, then NORM.
  - NORM (1 cycle): normalise, round, range-check, write result and flags, then DONE.
    - Normal-path latency: out_valid first high MAN_W+2 edges after the accepting edge (25 for defaults).
  - DONE: out_valid=1; result and flags held stable while out_ready=0. On out_ready=1, next state IDLE.
    - in_ready=0 in DONE; no overlap of a new accept with the output handshake.
- Operand classification (per operand):
  - exp=0: treated as zero; subnormals are flushed.
  - exp=all-ones with frac=0: inf.
  - exp=all-ones with frac!=0: NaN.
- Special-case priority:
  - NaN operand, or zero*inf: result={0, all-ones, 1, zeros} (quiet NaN), nan=1.
  - Zero operand: result={sX^sY, 0...}, zero=1.
  - Inf operand: result={sX^sY, all-ones, 0}, inf=1.
- Arithmetic:
  - Product is 2*(MAN_W+1) bits. If MSB=1: fraction taken from the bits below the MSB, exponent +1; else from bits below MSB-1.
  - Biased exponent e = eX + eY - BIAS + norm, computed signed at EXP_W+2 bits.
  - Rounding carry-out that renormalises increments e.
  - e <= 0: result = signed zero, underflow=1.
  - e >= 2^EXP_W-1: result = signed inf, overflow=1 (inf=0).
  - Otherwise: result = {sX^sY, e[EXP_W-1:0], frac}, all flags 0.

Optional Feature:
- ROUND_NEAREST_EN defined: round-to-nearest-even using guard bit plus sticky (OR of all lower product bits); a tie rounds to even LSB.
- Not defined: truncation. Flags and latency are identical in both builds.

Decomposition:
- Package fp_mult_pkg:
  - state_t enum {IDLE, MUL, NORM, DONE};
  - fp_class_t enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN};
  - functions for BIAS, quiet-NaN and signed-inf patterns, parameterised by EXP_W/MAN_W.
- One natural sub-module: fp_classify, a combinational per-operand classifier (instantiated twice).

Test Plan:
- FP32: 0x3FC00000*0x40000000 -> 0x40400000, no flags, out_valid after 25 edges; -2.5*4.0 (0xC0200000*0x40800000) -> 0xC1200000.
- 0x7FC00001*0x3F800000 -> 0x7FC00000, nan=1, out_valid 1 cycle after accept; 0x00000000*0x7F800000 -> 0x7FC00000, nan=1; 0x80000000*0x3F800000 -> 0x80000000, zero=1.
- 0x7F000000*0x7F000000 -> 0x7F800000, overflow=1; 0x00800000*0x00800000 -> 0x00000000, underflow=1; 0xFF800000*0x40000000 -> 0xFF800000, inf=1.
- 0x3FC00001*0x3FC00001 -> 0x40100002 with ROUND_NEAREST_EN, 0x40100001 without.
- Hold out_ready=0 for 10 cycles in DONE -> result/flags stable, in_ready=0; then out_ready=1 -> IDLE; back-to-back operation accepted the following cycle.
- reset_n=0 during MUL (cycle 5) -> next edge out_valid=0, in_ready=1; following op 1.0*1.0 -> 0x3F800000. Repeat with EXP_W=5, MAN_W=10: 0x3E00*0x4000 -> 0x4200.

Source files
------------

// File: rtl/fp_mult_pkg.sv
// Shared types and constant helpers for the sequential floating-point multiplier.
package fp_mult_pkg;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
    typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Quiet NaN: sign 0, exponent all ones, fraction MSB set.
    function automatic logic [63:0] fp_qnan_bits(input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | (64'd1 << (man_w - 1));
        return r;
    endfunction

    // Infinity magnitude (no sign bit): exponent all ones, fraction zero.
    function automatic logic [63:0] fp_inf_bits(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

endpackage

// File: rtl/fp_mult_if.sv
// Operand/result bus of the multiplier.
// A transfer happens on a rising edge where valid and ready are both high; valid
// never waits on ready, and the producer holds its payload until the transfer.
interface fp_mult_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         inf;
    logic         nan;
    logic         zero;
    logic         overflow;
    logic         underflow;

    modport slave (
        input  in_valid, X, Y, out_ready,
        output in_ready, out_valid, result, inf, nan, zero, overflow, underflow
    );

    modport master (
        output in_valid, X, Y, out_ready,
        input  in_ready, out_valid, result, inf, nan, zero, overflow, underflow
    );
endinterface

// File: rtl/fp_classify.sv
// Per-operand classifier: zero (subnormals flushed), normal, infinity or NaN.
module fp_classify
    import fp_mult_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W-1:0] exp_i,
    input  logic [MAN_W-1:0] frac_i,
    output fp_class_t        cls_o
);
    always_comb begin
        cls_o = FP_NORM;
        if (exp_i == '0) begin
            cls_o = FP_ZERO;
        end else if (&exp_i) begin
            cls_o = (frac_i == '0) ? FP_INF : FP_NAN;
        end
    end
endmodule

// File: rtl/fp_mult_seq.sv
// Sequential shift-add floating-point multiplier with valid/ready handshake.
// Optional build macro ROUND_NEAREST_EN selects round-to-nearest-even; default truncates.
module fp_mult_seq
    import fp_mult_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic      clk,
    input  logic      reset_n,
    fp_mult_if.slave  bus,
    output state_t    state_dbg
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 1;
    localparam int PW  = 2 * SW;
    localparam int CW  = $clog2(SW + 1);
    localparam int EW2 = EXP_W + 2;

    localparam logic [W-1:0]   QNAN    = W'(fp_qnan_bits(EXP_W, MAN_W));
    localparam logic [W-2:0]   INF_MAG = (W-1)'(fp_inf_bits(EXP_W, MAN_W));
    localparam logic [EW2-1:0] BIAS_E  = EW2'(fp_bias(EXP_W));
    localparam logic [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);
`ifdef ROUND_NEAREST_EN
    localparam bit RND_EN = 1'b1;
`else
    localparam bit RND_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic             sign_q, sign_d;
    logic [EXP_W-1:0] ex_q, ex_d, ey_q, ey_d;
    logic [PW-1:0]    acc_q, acc_d, mcand_q, mcand_d;
    logic [SW-1:0]    mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic             inf_q, inf_d, nan_q, nan_d, zero_q, zero_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;

    fp_class_t cls_x, cls_y;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_x (
        .exp_i (bus.X[W-2:MAN_W]),
        .frac_i(bus.X[MAN_W-1:0]),
        .cls_o (cls_x)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_y (
        .exp_i (bus.Y[W-2:MAN_W]),
        .frac_i(bus.Y[MAN_W-1:0]),
        .cls_o (cls_y)
    );

    // Normalisation view of the finished product: drop the leading one, keep the rest.
    logic             prod_msb, guard, sticky, round_up;
    logic [PW-2:0]    norm_low;
    logic [MAN_W-1:0] frac_t;
    logic [MAN_W:0]   frac_r;
    logic [EW2-1:0]   e_calc;

    always_comb begin
        prod_msb = acc_q[PW-1];
        norm_low = prod_msb ? acc_q[PW-2:0] : {acc_q[PW-3:0], 1'b0};
        frac_t   = norm_low[PW-2 -: MAN_W];
        guard    = norm_low[MAN_W];
        sticky   = |norm_low[MAN_W-1:0];
        round_up = RND_EN & guard & (sticky | frac_t[0]);
        frac_r   = {1'b0, frac_t} + (MAN_W+1)'(round_up);
        // A carry out of the rounded fraction means 1.11..1 became 10.00..0.
        e_calc   = EW2'(ex_q) + EW2'(ey_q) - BIAS_E + EW2'(prod_msb) + EW2'(frac_r[MAN_W]);
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        ex_d        = ex_q;
        ey_d        = ey_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        inf_d       = inf_q;
        nan_d       = nan_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d = bus.X[W-1] ^ bus.Y[W-1];
                    ex_d   = bus.X[W-2:MAN_W];
                    ey_d   = bus.Y[W-2:MAN_W];
                    inf_d  = 1'b0;
                    nan_d  = 1'b0;
                    zero_d = 1'b0;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    if (cls_x == FP_NAN || cls_y == FP_NAN ||
                        (cls_x == FP_ZERO && cls_y == FP_INF) ||
                        (cls_x == FP_INF && cls_y == FP_ZERO)) begin
                        result_d    = QNAN;
                        nan_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (cls_x == FP_ZERO || cls_y == FP_ZERO) begin
                        result_d    = {sign_d, {(W-1){1'b0}}};
                        zero_d      = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (cls_x == FP_INF || cls_y == FP_INF) begin
                        result_d    = {sign_d, INF_MAG};
                        inf_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        acc_d    = '0;
                        mcand_d  = PW'({1'b1, bus.X[MAN_W-1:0]});
                        mplier_d = {1'b1, bus.Y[MAN_W-1:0]};
                        cnt_d    = '0;
                        state_d  = MUL;
                    end
                end
            end
            MUL: begin
                // The multiplicand register is pre-shifted, so it always holds sigX << cnt.
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(SW - 1)) state_d = NORM;
            end
            NORM: begin
                if (e_calc[EW2-1] || e_calc == '0) begin
                    result_d = {sign_q, {(W-1){1'b0}}};
                    unf_d    = 1'b1;
                end else if (e_calc >= EXP_MAX) begin
                    result_d = {sign_q, INF_MAG};
                    ovf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, e_calc[EXP_W-1:0], frac_r[MAN_W-1:0]};
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            ex_q        <= '0;
            ey_q        <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            inf_q       <= 1'b0;
            nan_q       <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            ex_q        <= ex_d;
            ey_q        <= ey_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            inf_q       <= inf_d;
            nan_q       <= nan_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.inf       = inf_q;
    assign bus.nan       = nan_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_fp_mult_seq.sv
// Directed bench for fp_mult_seq: an FP32 instance and a 5/10-bit instance sharing clock and reset.
module tb_fp_mult_seq;
    import fp_mult_pkg::*;

    logic   clk = 1'b0;
    logic   reset_n = 1'b0;
    state_t st32, st16;

    fp_mult_if #(.EXP_W(8), .MAN_W(23)) b32();
    fp_mult_if #(.EXP_W(5), .MAN_W(10)) b16();

    fp_mult_seq #(.EXP_W(8), .MAN_W(23)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .bus(b32), .state_dbg(st32)
    );
    fp_mult_seq #(.EXP_W(5), .MAN_W(10)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .bus(b16), .state_dbg(st16)
    );

    always #5 clk = ~clk;

    // flags packed as {inf, nan, zero, overflow, underflow}
    typedef struct {
        bit          h;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        logic [4:0]  flags;
        int          lat;
    } vec_t;

    int n_vec = 0;
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic get_valid(input bit h);
        return h ? b16.out_valid : b32.out_valid;
    endfunction

    function automatic logic get_ready(input bit h);
        return h ? b16.in_ready : b32.in_ready;
    endfunction

    function automatic logic [31:0] get_res(input bit h);
        return h ? {16'h0, b16.result} : b32.result;
    endfunction

    function automatic logic [4:0] get_flags(input bit h);
        return h ? {b16.inf, b16.nan, b16.zero, b16.overflow, b16.underflow}
                 : {b32.inf, b32.nan, b32.zero, b32.overflow, b32.underflow};
    endfunction

    function automatic logic [1:0] get_state(input bit h);
        return h ? st16 : st32;
    endfunction

    // Present operands at a falling edge; returns #1 after the accepting rising edge.
    task automatic drive_op(input bit h, input logic [31:0] x, input logic [31:0] y, input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(get_ready(h)), 64'd1);
        if (h) begin
            b16.in_valid = 1'b1; b16.X = x[15:0]; b16.Y = y[15:0];
        end else begin
            b32.in_valid = 1'b1; b32.X = x; b32.Y = y;
        end
        @(posedge clk);
        #1;
        b16.in_valid = 1'b0;
        b32.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input bit h, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!get_valid(h) && lat < 200);
    endtask

    task automatic release_out(input bit h);
        @(negedge clk);
        if (h) b16.out_ready = 1'b1; else b32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b16.out_ready = 1'b0;
        b32.out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        drive_op(v.h, v.x, v.y, tag);
        wait_valid(v.h, lat);
        check({tag, "_result"}, 64'(get_res(v.h)), 64'(v.res));
        check({tag, "_flags"}, 64'(get_flags(v.h)), 64'(v.flags));
        check({tag, "_latency"}, 64'(lat), 64'(v.lat));
        release_out(v.h);
        n_vec++;
    endtask

    vec_t vecs[14];

    initial begin
        int   lat;
        vec_t v;

        vecs[0]  = '{0, 32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000, 25};
        vecs[1]  = '{0, 32'hC0200000, 32'h40800000, 32'hC1200000, 5'b00000, 25};
        vecs[2]  = '{0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b01000, 1};
        vecs[3]  = '{0, 32'h00000000, 32'h7F800000, 32'h7FC00000, 5'b01000, 1};
        vecs[4]  = '{0, 32'h80000000, 32'h3F800000, 32'h80000000, 5'b00100, 1};
        vecs[5]  = '{0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 5'b00010, 25};
        vecs[6]  = '{0, 32'h00800000, 32'h00800000, 32'h00000000, 5'b00001, 25};
        vecs[7]  = '{0, 32'hFF800000, 32'h40000000, 32'hFF800000, 5'b10000, 1};
`ifdef ROUND_NEAREST_EN
        vecs[8]  = '{0, 32'h3FC00001, 32'h3FC00001, 32'h40100002, 5'b00000, 25};
`else
        vecs[8]  = '{0, 32'h3FC00001, 32'h3FC00001, 32'h40100001, 5'b00000, 25};
`endif
        vecs[9]  = '{0, 32'h40400000, 32'h40400000, 32'h41100000, 5'b00000, 25};
        vecs[10] = '{0, 32'h80000000, 32'hBF800000, 32'h00000000, 5'b00100, 1};
        vecs[11] = '{0, 32'h7F800001, 32'h00000000, 32'h7FC00000, 5'b01000, 1};
        vecs[12] = '{1, 32'h00003C00, 32'h00003C00, 32'h00003C00, 5'b00000, 12};
        vecs[13] = '{1, 32'h00007800, 32'h00007800, 32'h00007C00, 5'b00010, 12};

        b32.in_valid = 1'b0; b32.X = '0; b32.Y = '0; b32.out_ready = 1'b0;
        b16.in_valid = 1'b0; b16.X = '0; b16.Y = '0; b16.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset32", {25'h0, b32.out_valid, b32.in_ready, get_flags(0), b32.result},
              {25'h0, 1'b0, 1'b1, 5'b0, 32'h0});
        check("reset16", {41'h0, b16.out_valid, b16.in_ready, get_flags(1), b16.result},
              {41'h0, 1'b0, 1'b1, 5'b0, 16'h0});
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Stall in DONE, then back-to-back accept right after the release.
        drive_op(0, 32'h3FC00000, 32'h40000000, "hold");
        wait_valid(0, lat);
        check("hold_latency", 64'(lat), 64'd25);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_stable%0d", i),
                  {25'h0, b32.out_valid, b32.in_ready, get_flags(0), b32.result},
                  {25'h0, 1'b1, 1'b0, 5'b0, 32'h40400000});
        end
        @(negedge clk);
        b32.out_ready = 1'b1;
        b32.in_valid = 1'b1; b32.X = 32'hC0200000; b32.Y = 32'h40800000;
        @(posedge clk);
        #1;
        b32.out_ready = 1'b0;
        check("release_idle", {62'h0, b32.in_ready, b32.out_valid}, {62'h0, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        b32.in_valid = 1'b0;
        check("b2b_accept_state", 64'(get_state(0)), 64'(MUL));
        wait_valid(0, lat);
        check("b2b_latency", 64'(lat), 64'd25);
        check("b2b_result", 64'(get_res(0)), 64'hC1200000);
        release_out(0);
        n_vec++;

        // Reset during MUL for both widths, then a clean operation.
        for (int h = 0; h < 2; h++) begin
            drive_op(h[0], h[0] ? 32'h00003E00 : 32'h3FC00000,
                     h[0] ? 32'h00004000 : 32'h40000000, $sformatf("rst%0d", h));
            repeat (4) @(posedge clk);
            @(negedge clk);
            reset_n = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("rst%0d_outputs", h),
                  {61'h0, get_valid(h[0]), get_ready(h[0]), get_state(h[0]) == IDLE},
                  {61'h0, 1'b0, 1'b1, 1'b1});
            @(negedge clk);
            reset_n = 1'b1;
            v = h[0] ? '{1, 32'h00003E00, 32'h00004000, 32'h00004200, 5'b00000, 12}
                     : '{0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 25};
            run_vec(v, $sformatf("post_rst%0d", h));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
